// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry controller.
// Key codes, FSM state encoding, buffer type and a count-to-enable helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_FULL,
      ST_DONE
   } state_e;

   typedef logic [15:0] keyBuf_t;

   localparam logic [3:0] KEY_BACK  = 4'd10;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
   localparam logic [3:0] KEY_ENTER = 4'd12;

   // Lowest 'count' digit enables set; counts above four saturate to all digits.
   function automatic logic [3:0] countMask(input logic [2:0] count);
      case (count)
         3'd0:    countMask = 4'b0000;
         3'd1:    countMask = 4'b0001;
         3'd2:    countMask = 4'b0011;
         3'd3:    countMask = 4'b0111;
         default: countMask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/key_entry_ctrl_if.sv
// Keypad/display bundle between the controller and its environment.
// The master drives scan strobes and key states; the slave (controller) drives the display.
interface key_entry_ctrl_if;
   import keypad_pkg::*;

   logic        scan_tick;
   logic [15:0] key_out;
   keyBuf_t     disp_val;
   logic [3:0]  disp_en;
   keyBuf_t     entry_val;
   logic        entry_valid;
   logic        key_err;

   modport master (
      output scan_tick, key_out,
      input  disp_val, disp_en, entry_val, entry_valid, key_err
   );

   modport slave (
      input  scan_tick, key_out,
      output disp_val, disp_en, entry_val, entry_valid, key_err
   );

endinterface

// File: rtl/key_edge_detect.sv
// Samples the active-low key matrix on each scan tick and reports the lowest-index
// key that went from released to held since the previous sample.
module key_edge_detect (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        sample_i,
   input  logic [15:0] key_i,
   output logic        press_o,
   output logic [3:0]  code_o
);

   logic [15:0] prevSample_q;
   logic [15:0] pressed;

   // Previous sample starts all-released so keys already down at reset do not count.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prevSample_q <= 16'hFFFF;
      end else if (sample_i) begin
         prevSample_q <= key_i;
      end
   end

   always_comb begin
      pressed = prevSample_q & ~key_i;
      press_o = sample_i & (|pressed);
      code_o  = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pressed[i]) begin
            code_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/key_entry_ctrl.sv
// Four-digit keypad entry controller: digit buffer with BACK/CLEAR/ENTER editing,
// committed-entry output and a timed, blinking DONE display.
module key_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int HOLD_TICKS  = 200,
   parameter int BLINK_TICKS = 50
) (
   input  logic             clk_in,
   input  logic             rst_in,
   key_entry_ctrl_if.slave  bus
);

   localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
   localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

   logic       press;
   logic [3:0] keyCode;

   state_e               state_q, state_d;
   keyBuf_t              buf_q, buf_d;
   logic [2:0]           count_q, count_d;
   logic [HOLD_W-1:0]    holdCnt_q, holdCnt_d;
   logic [BLINK_W-1:0]   blinkCnt_q, blinkCnt_d;
   logic                 blinkOn_q, blinkOn_d;
   keyBuf_t              entryVal_q, entryVal_d;
   logic                 entryValid_q, entryValid_d;
   logic                 keyErr_q, keyErr_d;

   key_edge_detect u_edge (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .sample_i (bus.scan_tick),
      .key_i    (bus.key_out),
      .press_o  (press),
      .code_o   (keyCode)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         buf_q        <= '0;
         count_q      <= '0;
         holdCnt_q    <= '0;
         blinkCnt_q   <= '0;
         blinkOn_q    <= 1'b0;
         entryVal_q   <= '0;
         entryValid_q <= 1'b0;
         keyErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         count_q      <= count_d;
         holdCnt_q    <= holdCnt_d;
         blinkCnt_q   <= blinkCnt_d;
         blinkOn_q    <= blinkOn_d;
         entryVal_q   <= entryVal_d;
         entryValid_q <= entryValid_d;
         keyErr_q     <= keyErr_d;
      end
   end

   // Timers run first in DONE so that a key press on the same tick overrides the timeout.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      count_d      = count_q;
      holdCnt_d    = holdCnt_q;
      blinkCnt_d   = blinkCnt_q;
      blinkOn_d    = blinkOn_q;
      entryVal_d   = entryVal_q;
      entryValid_d = 1'b0;
      keyErr_d     = 1'b0;

      if (bus.scan_tick && state_q == ST_DONE) begin
         if (holdCnt_q == HOLD_W'(HOLD_TICKS - 1)) begin
            state_d = ST_IDLE;
            buf_d   = '0;
            count_d = '0;
         end else begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
         end
         if (blinkCnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
            blinkCnt_d = '0;
            blinkOn_d  = ~blinkOn_q;
         end else begin
            blinkCnt_d = blinkCnt_q + BLINK_W'(1);
         end
      end

      if (press) begin
         if (keyCode <= 4'd9) begin
            case (state_q)
               ST_IDLE, ST_ENTRY: begin
                  buf_d   = {buf_q[11:0], keyCode};
                  count_d = count_q + 3'd1;
                  state_d = (count_q == 3'd3) ? ST_FULL : ST_ENTRY;
               end
               ST_FULL: keyErr_d = 1'b1;
               default: begin
                  buf_d   = {12'h000, keyCode};
                  count_d = 3'd1;
                  state_d = ST_ENTRY;
               end
            endcase
         end else if (keyCode == KEY_BACK) begin
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
               keyErr_d = 1'b1;
            end else begin
               buf_d   = {4'h0, buf_q[15:4]};
               count_d = count_q - 3'd1;
               state_d = (count_q == 3'd1) ? ST_IDLE : ST_ENTRY;
            end
         end else if (keyCode == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = '0;
            state_d = ST_IDLE;
         end else if (keyCode == KEY_ENTER) begin
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
               keyErr_d = 1'b1;
            end else begin
               entryVal_d   = buf_q;
               entryValid_d = 1'b1;
               state_d      = ST_DONE;
               holdCnt_d    = '0;
               blinkCnt_d   = '0;
               blinkOn_d    = 1'b1;
            end
         end
      end
   end

   assign bus.disp_val    = buf_q;
   assign bus.disp_en     = (state_q != ST_DONE || blinkOn_q) ? countMask(count_q) : 4'b0000;
   assign bus.entry_val   = entryVal_q;
   assign bus.entry_valid = entryValid_q;
   assign bus.key_err     = keyErr_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: scripted key sequences with hand-computed
// display, entry and pulse expectations checked by immediate assertions.
module tb_key_entry_ctrl;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;

   int errorCount  = 0;
   int checkCount  = 0;
   int validPulses = 0;
   int preValid;

   logic lastErr;
   logic lastValid;

   key_entry_ctrl_if bus ();

   key_entry_ctrl #(
      .HOLD_TICKS  (200),
      .BLINK_TICKS (50)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (bus.entry_valid === 1'b1) validPulses++;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One idle cycle, then a single-cycle scan tick carrying the given key state.
   task automatic applyStimulus(input logic [15:0] keys);
      @(negedge clk_in);
      bus.key_out   = keys;
      bus.scan_tick = 1'b1;
      @(negedge clk_in);
      bus.scan_tick = 1'b0;
   endtask

   task automatic tapKey(input int k);
      logic [15:0] keys;
      keys    = 16'hFFFF;
      keys[k] = 1'b0;
      applyStimulus(keys);
      lastErr   = bus.key_err;
      lastValid = bus.entry_valid;
      applyStimulus(16'hFFFF);
   endtask

   initial begin
      bus.scan_tick = 1'b0;
      bus.key_out   = 16'hFFFF;
      lastErr       = 1'b0;
      lastValid     = 1'b0;

      $display("[TB] reset state");
      repeat (2) @(negedge clk_in);
      checkOutput("rst_disp_val", bus.disp_val, 16'h0000);
      checkOutput("rst_disp_en", {12'h0, bus.disp_en}, 16'h0000);
      checkOutput("rst_entry_val", bus.entry_val, 16'h0000);
      checkOutput("rst_entry_valid", {15'h0, bus.entry_valid}, 16'h0000);
      checkOutput("rst_key_err", {15'h0, bus.key_err}, 16'h0000);
      rst_in = 1'b0;

      $display("[TB] 1,2,3 ENTER");
      tapKey(1);
      tapKey(2);
      tapKey(3);
      checkOutput("e123_disp_val", bus.disp_val, 16'h0123);
      checkOutput("e123_disp_en", {12'h0, bus.disp_en}, 16'h0007);
      tapKey(12);
      checkOutput("e123_valid_pulse", {15'h0, lastValid}, 16'h0001);
      checkOutput("e123_entry_val", bus.entry_val, 16'h0123);
      checkOutput("e123_valid_low", {15'h0, bus.entry_valid}, 16'h0000);
      checkOutput("e123_lit", {12'h0, bus.disp_en}, 16'h0007);
      repeat (48) applyStimulus(16'hFFFF);
      checkOutput("blink_t49_lit", {12'h0, bus.disp_en}, 16'h0007);
      applyStimulus(16'hFFFF);
      checkOutput("blink_t50_dark", {12'h0, bus.disp_en}, 16'h0000);
      repeat (50) applyStimulus(16'hFFFF);
      checkOutput("blink_t100_lit", {12'h0, bus.disp_en}, 16'h0007);
      tapKey(12);
      checkOutput("enter_in_done_err", {15'h0, lastErr}, 16'h0001);
      checkOutput("enter_in_done_novalid", {15'h0, lastValid}, 16'h0000);
      checkOutput("one_valid_pulse", 16'(validPulses), 16'd1);
      tapKey(11);
      checkOutput("clear_disp_val", bus.disp_val, 16'h0000);
      checkOutput("clear_disp_en", {12'h0, bus.disp_en}, 16'h0000);

      $display("[TB] 9,8,7,6,5 overflow");
      tapKey(9);
      tapKey(8);
      tapKey(7);
      tapKey(6);
      checkOutput("full_disp_val", bus.disp_val, 16'h9876);
      checkOutput("full_disp_en", {12'h0, bus.disp_en}, 16'h000F);
      tapKey(5);
      checkOutput("full_err_pulse", {15'h0, lastErr}, 16'h0001);
      checkOutput("full_unchanged", bus.disp_val, 16'h9876);
      checkOutput("full_err_low", {15'h0, bus.key_err}, 16'h0000);
      tapKey(11);

      $display("[TB] sampling only on scan_tick");
      bus.key_out = 16'hFFEF;
      repeat (3) @(negedge clk_in);
      checkOutput("no_tick_no_action", bus.disp_val, 16'h0000);
      bus.key_out = 16'hFFFF;

      $display("[TB] simultaneous 3 and 7, held 3");
      applyStimulus(16'hFF77);
      checkOutput("multi_lowest", bus.disp_val, 16'h0003);
      checkOutput("multi_count", {12'h0, bus.disp_en}, 16'h0001);
      repeat (10) applyStimulus(16'hFFF7);
      applyStimulus(16'hFFFF);
      checkOutput("held_no_repeat", bus.disp_val, 16'h0003);
      tapKey(11);

      $display("[TB] 4,5 then BACK x3");
      tapKey(4);
      tapKey(5);
      checkOutput("back_pre", bus.disp_val, 16'h0045);
      tapKey(10);
      checkOutput("back1_val", bus.disp_val, 16'h0004);
      checkOutput("back1_en", {12'h0, bus.disp_en}, 16'h0001);
      tapKey(10);
      checkOutput("back2_err", {15'h0, lastErr}, 16'h0000);
      checkOutput("back2_en", {12'h0, bus.disp_en}, 16'h0000);
      tapKey(10);
      checkOutput("back3_err", {15'h0, lastErr}, 16'h0001);
      checkOutput("back3_val", bus.disp_val, 16'h0000);

      $display("[TB] DONE timeout");
      tapKey(7);
      tapKey(12);
      repeat (198) applyStimulus(16'hFFFF);
      checkOutput("t199_disp_val", bus.disp_val, 16'h0007);
      checkOutput("t199_dark", {12'h0, bus.disp_en}, 16'h0000);
      applyStimulus(16'hFFFF);
      checkOutput("t200_idle_val", bus.disp_val, 16'h0000);
      checkOutput("t200_idle_en", {12'h0, bus.disp_en}, 16'h0000);
      tapKey(1);
      checkOutput("after_timeout_count", {12'h0, bus.disp_en}, 16'h0001);
      tapKey(11);

      $display("[TB] digit on timeout tick");
      tapKey(7);
      tapKey(12);
      repeat (198) applyStimulus(16'hFFFF);
      applyStimulus(16'hFFFB);
      checkOutput("t200_digit_val", bus.disp_val, 16'h0002);
      checkOutput("t200_digit_en", {12'h0, bus.disp_en}, 16'h0001);
      applyStimulus(16'hFFFF);
      tapKey(5);
      checkOutput("t200_then_5", bus.disp_val, 16'h0025);
      tapKey(11);

      $display("[TB] reset mid-entry");
      tapKey(1);
      tapKey(2);
      checkOutput("mid_val", bus.disp_val, 16'h0012);
      checkOutput("mid_en", {12'h0, bus.disp_en}, 16'h0003);
      preValid = validPulses;
      @(negedge clk_in);
      bus.key_out   = 16'hEFFF;
      bus.scan_tick = 1'b1;
      #2 rst_in = 1'b1;
      #1;
      checkOutput("async_disp_val", bus.disp_val, 16'h0000);
      checkOutput("async_disp_en", {12'h0, bus.disp_en}, 16'h0000);
      checkOutput("async_entry_val", bus.entry_val, 16'h0000);
      checkOutput("async_entry_valid", {15'h0, bus.entry_valid}, 16'h0000);
      checkOutput("async_key_err", {15'h0, bus.key_err}, 16'h0000);
      @(negedge clk_in);
      bus.scan_tick = 1'b0;
      bus.key_out   = 16'hFFFF;
      checkOutput("rst_hold_valid", {15'h0, bus.entry_valid}, 16'h0000);
      checkOutput("rst_no_pulse", 16'(validPulses - preValid), 16'd0);
      rst_in = 1'b0;
      tapKey(3);
      checkOutput("post_rst_entry", bus.disp_val, 16'h0003);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
